// File: rtl/aes_comp_dec_if.sv
// Handshake/data bundle for the iterative AES-128 decryption core.
// Optional Dvld completion pulse exists only when AES_COMP_DEC_DVLD_EN is defined.
interface aes_comp_dec_if;
  logic         EN;
  logic [127:0] Kin;
  logic         Krdy;
  logic [127:0] Din;
  logic         Drdy;
  logic [127:0] Dout;
  logic         BSY;
  logic         Kvld;
`ifdef AES_COMP_DEC_DVLD_EN
  logic         Dvld;

  modport master (output EN, Kin, Krdy, Din, Drdy, input Dout, BSY, Kvld, Dvld);
  modport slave  (input EN, Kin, Krdy, Din, Drdy, output Dout, BSY, Kvld, Dvld);
`else
  modport master (output EN, Kin, Krdy, Din, Drdy, input Dout, BSY, Kvld);
  modport slave  (input EN, Kin, Krdy, Din, Drdy, output Dout, BSY, Kvld);
`endif
endinterface

// File: rtl/aes_comp_dec.sv
// Iterative AES-128 decryption core: one round per clock, reverse key schedule computed on the fly.
// Define AES_COMP_DEC_DVLD_EN to add the one-cycle Dvld completion pulse.
module aes_comp_dec #(
  parameter int NR = 10
) (
  input  logic           CLK,
  input  logic           RST,
  aes_comp_dec_if.slave  bus
);

  if (NR != 10) begin : g_bad_nr
    $error("aes_comp_dec supports only NR=10 (AES-128)");
  end

  typedef enum logic [1:0] {IDLE, KEXP, DEC} state_t;

  state_t       state_reg;
  logic [127:0] krgx_reg;
  logic [127:0] krgl_reg;
  logic [127:0] drg_reg;
  logic [9:0]   rnd_reg;
  logic         bsy_reg;
  logic         kvld_reg;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^-1 = x^16 * (x^17)^-1; the norm x^17 lives in the GF(2^4) subfield, where n^-1 = n^14.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x16, n, n2, n4, n8;
    x16 = gf_mul(a, a);
    x16 = gf_mul(x16, x16);
    x16 = gf_mul(x16, x16);
    x16 = gf_mul(x16, x16);
    n   = gf_mul(x16, a);
    n2  = gf_mul(n, n);
    n4  = gf_mul(n2, n2);
    n8  = gf_mul(n4, n4);
    return gf_mul(gf_mul(gf_mul(n2, n4), n8), x16);
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  function automatic logic [7:0] rcon_at(input int i);
    case (i)
      0: return 8'h01;
      1: return 8'h02;
      2: return 8'h04;
      3: return 8'h08;
      4: return 8'h10;
      5: return 8'h20;
      6: return 8'h40;
      7: return 8'h80;
      8: return 8'h1b;
      9: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Round constants: forward order during KEXP, reversed order during DEC.
  logic [9:0][7:0] rcon_fwd_terms;
  logic [9:0][7:0] rcon_inv_terms;
  logic [7:0]      rcon_fwd;
  logic [7:0]      rcon_inv;

  genvar gi;
  for (gi = 0; gi < 10; gi++) begin : g_rcon
    assign rcon_fwd_terms[gi] = rnd_reg[gi] ? rcon_at(gi) : 8'h00;
    assign rcon_inv_terms[gi] = rnd_reg[gi] ? rcon_at(9 - gi) : 8'h00;
  end

  always_comb begin
    rcon_fwd = 8'h00;
    rcon_inv = 8'h00;
    for (int i = 0; i < 10; i++) begin
      rcon_fwd = rcon_fwd | rcon_fwd_terms[i];
      rcon_inv = rcon_inv | rcon_inv_terms[i];
    end
  end

  // One shared SubWord: RotWord(w3) going forward, RotWord(w3^w2) going backward.
  logic [31:0]  w0, w1, w2, w3, w3_prev, sub_in, sub_out;
  logic [31:0]  f0, f1, f2, f3;
  logic [127:0] k_fwd, k_inv;

  assign {w0, w1, w2, w3} = krgx_reg;
  assign w3_prev = w3 ^ w2;
  assign sub_in  = (state_reg == DEC) ? {w3_prev[23:0], w3_prev[31:24]} : {w3[23:0], w3[31:24]};

  for (gi = 0; gi < 4; gi++) begin : g_subword
    assign sub_out[31 - 8*gi -: 8] = fwd_sbox(sub_in[31 - 8*gi -: 8]);
  end

  assign f0    = w0 ^ sub_out ^ {rcon_fwd, 24'h000000};
  assign f1    = w1 ^ f0;
  assign f2    = w2 ^ f1;
  assign f3    = w3 ^ f2;
  assign k_fwd = {f0, f1, f2, f3};
  assign k_inv = {w0 ^ sub_out ^ {rcon_inv, 24'h000000}, w1 ^ w0, w2 ^ w1, w3_prev};

  // Byte 0 is [127:120], column-major; row r rotates right by r.
  logic [127:0] t_state, imc_state, d_next;

  for (gi = 0; gi < 16; gi++) begin : g_inv_sbox
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    localparam int SRC = 4 * ((COL + 4 - ROW) % 4) + ROW;
    assign t_state[127 - 8*gi -: 8] = inv_sbox(drg_reg[127 - 8*SRC -: 8]) ^ k_inv[127 - 8*gi -: 8];
  end

  for (gi = 0; gi < 4; gi++) begin : g_inv_mix
    assign imc_state[127 - 32*gi -: 32] = inv_mix_col(t_state[127 - 32*gi -: 32]);
  end

  assign d_next = rnd_reg[9] ? t_state : imc_state;

`ifdef AES_COMP_DEC_DVLD_EN
  logic dvld_reg;
  assign bus.Dvld = dvld_reg;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      krgx_reg  <= '0;
      krgl_reg  <= '0;
      drg_reg   <= '0;
      rnd_reg   <= 10'b0000000001;
      bsy_reg   <= 1'b0;
      kvld_reg  <= 1'b0;
`ifdef AES_COMP_DEC_DVLD_EN
      dvld_reg  <= 1'b0;
`endif
    end else if (bus.EN) begin
`ifdef AES_COMP_DEC_DVLD_EN
      dvld_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (bus.Krdy) begin
            krgx_reg  <= bus.Kin;
            kvld_reg  <= 1'b0;
            bsy_reg   <= 1'b1;
            state_reg <= KEXP;
          end else if (bus.Drdy && kvld_reg) begin
            drg_reg   <= bus.Din ^ krgl_reg;
            krgx_reg  <= krgl_reg;
            bsy_reg   <= 1'b1;
            state_reg <= DEC;
          end
        end
        KEXP: begin
          krgx_reg <= k_fwd;
          if (rnd_reg[9]) begin
            krgl_reg  <= k_fwd;
            kvld_reg  <= 1'b1;
            bsy_reg   <= 1'b0;
            rnd_reg   <= 10'b0000000001;
            state_reg <= IDLE;
          end else begin
            rnd_reg <= {rnd_reg[8:0], 1'b0};
          end
        end
        DEC: begin
          drg_reg <= d_next;
          if (rnd_reg[9]) begin
            krgx_reg  <= krgl_reg;
            bsy_reg   <= 1'b0;
            rnd_reg   <= 10'b0000000001;
            state_reg <= IDLE;
`ifdef AES_COMP_DEC_DVLD_EN
            dvld_reg  <= 1'b1;
`endif
          end else begin
            krgx_reg <= k_inv;
            rnd_reg  <= {rnd_reg[8:0], 1'b0};
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.Dout = drg_reg;
  assign bus.BSY  = bsy_reg;
  assign bus.Kvld = kvld_reg;

endmodule

// File: tb/tb_aes_comp_dec.sv
// Bench for aes_comp_dec: FIPS-197 vectors, control corner cases and random keys/ciphertexts
// checked against a table-driven reference decryptor with a precomputed key schedule.
module tb_aes_comp_dec;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  aes_comp_dec_if bus ();

  aes_comp_dec #(.NR(10)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
`ifdef AES_COMP_DEC_DVLD_EN
  int dv_early;
`endif

  localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1L = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BL  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] BC  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] BP  = 128'h3243f6a8885a308d313198a2e0370734;

  // ---------------- reference model ----------------
  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk_m  [11];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Walk the multiplicative group with generator 3 and its inverse in lockstep.
  task automatic build_sbox();
    logic [7:0] p = 8'h01;
    logic [7:0] q = 8'h01;
    logic [7:0] x;
    do begin
      p = p ^ xt(p);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
    for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] model_dec(input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [127:0] k;
    logic [127:0] res;
    k = ct ^ rk_m[10];
    for (int i = 0; i < 16; i++) s[i] = k[127 - 8*i -: 8];
    for (int rd = 9; rd >= 0; rd--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          u[r + 4*c] = isbox[s[r + 4*((c - r + 4) % 4)]];
      k = rk_m[rd];
      for (int i = 0; i < 16; i++) u[i] = u[i] ^ k[127 - 8*i -: 8];
      if (rd > 0) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = gm(u[4*c], 8'h0e) ^ gm(u[4*c+1], 8'h0b) ^ gm(u[4*c+2], 8'h0d) ^ gm(u[4*c+3], 8'h09);
          s[4*c+1] = gm(u[4*c], 8'h09) ^ gm(u[4*c+1], 8'h0e) ^ gm(u[4*c+2], 8'h0b) ^ gm(u[4*c+3], 8'h0d);
          s[4*c+2] = gm(u[4*c], 8'h0d) ^ gm(u[4*c+1], 8'h09) ^ gm(u[4*c+2], 8'h0e) ^ gm(u[4*c+3], 8'h0b);
          s[4*c+3] = gm(u[4*c], 8'h0b) ^ gm(u[4*c+1], 8'h0d) ^ gm(u[4*c+2], 8'h09) ^ gm(u[4*c+3], 8'h0e);
        end
      end else begin
        for (int i = 0; i < 16; i++) s[i] = u[i];
      end
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Counts busy cycles; optionally stalls EN for 5 cycles or pokes strobes while busy.
  task automatic run_busy(input int stall_at, input bit poke, output int busy);
    busy = 0;
`ifdef AES_COMP_DEC_DVLD_EN
    dv_early = 0;
`endif
    while (bus.BSY === 1'b1 && busy < 100) begin
      busy++;
      if (busy == stall_at)     bus.EN = 1'b0;
      if (busy == stall_at + 5) bus.EN = 1'b1;
      if (poke && busy == 3) begin
        bus.Kin  = rand128();
        bus.Din  = rand128();
        bus.Krdy = 1'b1;
        bus.Drdy = 1'b1;
      end
      if (poke && busy == 4) begin
        bus.Krdy = 1'b0;
        bus.Drdy = 1'b0;
      end
`ifdef AES_COMP_DEC_DVLD_EN
      if (bus.Dvld === 1'b1) dv_early++;
`endif
      tick(1);
    end
    bus.EN = 1'b1;
  endtask

  task automatic do_key(input string tag, input logic [127:0] key, input logic [127:0] exp_l);
    int busy;
    bus.Kin  = key;
    bus.Krdy = 1'b1;
    tick(1);
    bus.Krdy = 1'b0;
    chk({tag, "_kvld_low"}, 128'(bus.Kvld), 128'(1'b0));
    run_busy(-100, 1'b0, busy);
    chk({tag, "_busy"}, 128'(busy), 128'(10));
    chk({tag, "_kvld"}, 128'(bus.Kvld), 128'(1'b1));
    chk({tag, "_krgl"}, dut.krgl_reg, exp_l);
`ifdef AES_COMP_DEC_DVLD_EN
    chk({tag, "_no_dvld"}, 128'(bus.Dvld), 128'(1'b0));
`endif
  endtask

  task automatic do_dec(input string tag, input logic [127:0] din, input logic [127:0] exp,
                        input int stall_at, input bit poke, input int exp_busy);
    int busy;
    bus.Din  = din;
    bus.Drdy = 1'b1;
    tick(1);
    bus.Drdy = 1'b0;
    run_busy(stall_at, poke, busy);
    chk({tag, "_busy"}, 128'(busy), 128'(exp_busy));
    chk({tag, "_dout"}, bus.Dout, exp);
`ifdef AES_COMP_DEC_DVLD_EN
    chk({tag, "_dvld_early"}, 128'(dv_early), 128'(0));
    chk({tag, "_dvld_pulse"}, 128'(bus.Dvld), 128'(1'b1));
    tick(1);
    chk({tag, "_dvld_clear"}, 128'(bus.Dvld), 128'(1'b0));
`endif
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int busy;
    logic [127:0] key;
    logic [127:0] ct;

    build_sbox();
    RST      = 1'b1;
    bus.EN   = 1'b1;
    bus.Krdy = 1'b0;
    bus.Drdy = 1'b0;
    bus.Kin  = '0;
    bus.Din  = '0;
    tick(2);
    chk("rst_dout", bus.Dout, 128'h0);
    chk("rst_bsy",  128'(bus.BSY),  128'(1'b0));
    chk("rst_kvld", 128'(bus.Kvld), 128'(1'b0));
    RST = 1'b0;

    // Ciphertext before any key: ignored.
    bus.Din  = C1C;
    bus.Drdy = 1'b1;
    tick(1);
    bus.Drdy = 1'b0;
    tick(2);
    chk("nokey_bsy",  128'(bus.BSY), 128'(1'b0));
    chk("nokey_dout", bus.Dout, 128'h0);

    do_key("c1_key", C1K, C1L);
    do_dec("c1", C1C, C1P, -100, 1'b0, 10);

    do_key("b_key", BK, BL);
    do_dec("b", BC, BP, -100, 1'b0, 10);
    do_dec("b_reuse", BC, BP, -100, 1'b0, 10);

    // Simultaneous Krdy/Drdy: key load wins, ciphertext dropped.
    bus.Kin  = C1K;
    bus.Din  = C1C;
    bus.Krdy = 1'b1;
    bus.Drdy = 1'b1;
    tick(1);
    bus.Krdy = 1'b0;
    bus.Drdy = 1'b0;
    run_busy(-100, 1'b0, busy);
    chk("both_busy", 128'(busy), 128'(10));
    chk("both_dout", bus.Dout, BP);
    chk("both_krgl", dut.krgl_reg, C1L);
    chk("both_kvld", 128'(bus.Kvld), 128'(1'b1));

    do_dec("c1_stall", C1C, C1P, 4, 1'b0, 15);

    // Reset during busy cycle 4 of a decrypt.
    bus.Din  = C1C;
    bus.Drdy = 1'b1;
    tick(1);
    bus.Drdy = 1'b0;
    tick(3);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    chk("abort_bsy",  128'(bus.BSY),  128'(1'b0));
    chk("abort_kvld", 128'(bus.Kvld), 128'(1'b0));
    chk("abort_dout", bus.Dout, 128'h0);
`ifdef AES_COMP_DEC_DVLD_EN
    chk("abort_dvld", 128'(bus.Dvld), 128'(1'b0));
`endif
    bus.Drdy = 1'b1;
    tick(1);
    bus.Drdy = 1'b0;
    tick(2);
    chk("abort_drdy_bsy",  128'(bus.BSY), 128'(1'b0));
    chk("abort_drdy_dout", bus.Dout, 128'h0);

    for (int i = 0; i < 6; i++) begin
      key = rand128();
      model_expand(key);
      do_key("rnd_key", key, rk_m[10]);
      for (int j = 0; j < 2; j++) begin
        ct = rand128();
        do_dec("rnd_dec", ct, model_dec(ct), -100, (j == 1), 10);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
